// File: rtl/pll_pkg.sv
// Shared types for the rPLL reset/lock sequencer: FSM states and divider-select payload.
package pll_pkg;

    localparam int unsigned SEL_W = 18;

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_LOCKED,
        S_RECONF,
        S_FAIL
    } pll_state_t;

    typedef struct packed {
        logic [5:0] idsel;
        logic [5:0] fbdsel;
        logic [5:0] odsel;
    } pll_sel_t;

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for the raw rPLL LOCK plus a consecutive-high lock filter.
module pll_lock_sync #(
    parameter int unsigned LOCK_FILT = 256
) (
    input  logic clkin,
    input  logic rst,
    input  logic lock_async,
    input  logic clr,
    output logic lock_s,
    output logic filt_done_c
);

    localparam int unsigned FW = $clog2(LOCK_FILT + 1);

    logic          sync1_q, sync2_q;
    logic [FW-1:0] filt_q, filt_d;

    // Saturating run-length counter of synchronised lock-high cycles.
    always_comb begin
        filt_d = filt_q;
        if (clr || !sync2_q) begin
            filt_d = '0;
        end else if (filt_q != FW'(LOCK_FILT)) begin
            filt_d = filt_q + FW'(1);
        end
    end

    // Asserted in the cycle the counter reaches LOCK_FILT.
    assign filt_done_c = !clr && sync2_q && (filt_q >= FW'(LOCK_FILT - 1));
    assign lock_s      = sync2_q;

    always_ff @(posedge clkin) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= '0;
        end else begin
            sync1_q <= lock_async;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
        end
    end

endmodule

// File: rtl/pll_seq.sv
// Gowin rPLL reset/lock sequencer. Runtime divider reconfiguration is built
// only when PLL_SEQ_RECONF_EN is defined.
module pll_seq
    import pll_pkg::*;
#(
    parameter int unsigned     RST_CYCLES   = 24,
    parameter int unsigned     LOCK_FILT    = 256,
    parameter int unsigned     LOCK_TIMEOUT = 24000,
    parameter int unsigned     MAX_RETRY    = 3,
    parameter logic [SEL_W-1:0] SEL_INIT    = '0
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       pll_reset_p,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    input  logic       cfg_req,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic       cfg_ack,
    output logic       locked,
    output logic       sys_rst,
    output logic       fail
);

    localparam int unsigned RW  = $clog2(RST_CYCLES + 1);
    localparam int unsigned TW  = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned RTW = $clog2(MAX_RETRY + 1);
    localparam pll_sel_t    SEL_INIT_S = pll_sel_t'(SEL_INIT);

    pll_state_t     state_q, state_d;
    logic [RW-1:0]  rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [RTW-1:0] retry_q, retry_d, retry_nxt;
    logic           pll_reset_q, pll_reset_d;
    logic           locked_q, locked_d;
    logic           sys_rst_q, sys_rst_d;
    logic           fail_q, fail_d;
    logic           lock_s, filt_done_c;

`ifdef PLL_SEQ_RECONF_EN
    pll_sel_t sel_q, sel_d;
    logic     cfg_ack_q, cfg_ack_d;
`endif

    pll_lock_sync #(.LOCK_FILT(LOCK_FILT)) u_lock_sync (
        .clkin       (clkin),
        .rst         (rst),
        .lock_async  (pll_lock),
        .clr         (state_q != S_WAIT_LOCK),
        .lock_s      (lock_s),
        .filt_done_c (filt_done_c)
    );

    assign retry_nxt = (retry_q == RTW'(MAX_RETRY)) ? retry_q : retry_q + RTW'(1);

    // Next state, counters, and outputs registered from the next state.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = '0;
        tmo_cnt_d = '0;
        retry_d   = retry_q;
`ifdef PLL_SEQ_RECONF_EN
        sel_d     = sel_q;
`endif
        case (state_q)
            S_RESET: begin
                if (rst_cnt_q >= RW'(RST_CYCLES - 1)) begin
                    state_d = S_WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            S_WAIT_LOCK: begin
                tmo_cnt_d = (tmo_cnt_q == TW'(LOCK_TIMEOUT)) ? tmo_cnt_q : tmo_cnt_q + TW'(1);
                if (filt_done_c) begin
                    state_d = S_LOCKED;
                    retry_d = '0;
                end else if (tmo_cnt_q >= TW'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_nxt;
                    state_d = (retry_nxt == RTW'(MAX_RETRY)) ? S_FAIL : S_RESET;
                end
            end
            S_LOCKED: begin
                // Lock loss outranks a request; the held request is seen on relock.
                if (!lock_s) begin
                    state_d = S_RESET;
`ifdef PLL_SEQ_RECONF_EN
                end else if (cfg_req) begin
                    state_d = S_RECONF;
                    sel_d   = pll_sel_t'({cfg_idsel, cfg_fbdsel, cfg_odsel});
`endif
                end
            end
            S_RECONF: begin
                retry_d = '0;
                state_d = S_RESET;
            end
            S_FAIL: begin
`ifdef PLL_SEQ_RECONF_EN
                if (cfg_req) begin
                    state_d = S_RECONF;
                    sel_d   = pll_sel_t'({cfg_idsel, cfg_fbdsel, cfg_odsel});
                end
`endif
            end
            default: state_d = S_RESET;
        endcase

        // RECONF keeps the previous reset level so a FAIL exit does not glitch RESET.
        case (state_d)
            S_RESET, S_FAIL: pll_reset_d = 1'b1;
            S_RECONF:        pll_reset_d = pll_reset_q;
            default:         pll_reset_d = 1'b0;
        endcase
        locked_d  = (state_d == S_LOCKED);
        sys_rst_d = (state_d != S_LOCKED);
        fail_d    = (state_d == S_FAIL);
`ifdef PLL_SEQ_RECONF_EN
        cfg_ack_d = (state_d == S_RECONF);
`endif
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q     <= S_RESET;
            rst_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            sys_rst_q   <= 1'b1;
            fail_q      <= 1'b0;
`ifdef PLL_SEQ_RECONF_EN
            sel_q       <= SEL_INIT_S;
            cfg_ack_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            locked_q    <= locked_d;
            sys_rst_q   <= sys_rst_d;
            fail_q      <= fail_d;
`ifdef PLL_SEQ_RECONF_EN
            sel_q       <= sel_d;
            cfg_ack_q   <= cfg_ack_d;
`endif
        end
    end

    assign pll_reset   = pll_reset_q;
    assign pll_reset_p = pll_reset_q;
    assign locked      = locked_q;
    assign sys_rst     = sys_rst_q;
    assign fail        = fail_q;

`ifdef PLL_SEQ_RECONF_EN
    assign cfg_ack    = cfg_ack_q;
    assign pll_idsel  = sel_q.idsel;
    assign pll_fbdsel = sel_q.fbdsel;
    assign pll_odsel  = sel_q.odsel;
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg_req, cfg_idsel, cfg_fbdsel, cfg_odsel};
    assign cfg_ack    = 1'b0;
    assign pll_idsel  = SEL_INIT_S.idsel;
    assign pll_fbdsel = SEL_INIT_S.fbdsel;
    assign pll_odsel  = SEL_INIT_S.odsel;
`endif

endmodule

// File: tb/tb_pll_seq.sv
// Self-checking bench for pll_seq; reconfiguration scenarios run when PLL_SEQ_RECONF_EN is defined.
module tb_pll_seq;

    localparam int          RST_C    = 4;
    localparam int          FILT     = 8;
    localparam int          TMO      = 50;
    localparam int          MAXR     = 2;
    localparam logic [17:0] SEL_INIT = 18'h0A5C3;

    logic       clkin = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       cfg_req = 1'b0;
    logic [5:0] cfg_idsel = '0, cfg_fbdsel = '0, cfg_odsel = '0;
    logic       pll_reset, pll_reset_p, cfg_ack, locked, sys_rst, fail;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;

    int checks = 0;
    int errors = 0;

    pll_seq #(
        .RST_CYCLES(RST_C), .LOCK_FILT(FILT), .LOCK_TIMEOUT(TMO),
        .MAX_RETRY(MAXR), .SEL_INIT(SEL_INIT)
    ) dut (
        .clkin(clkin), .rst(rst), .pll_lock(pll_lock),
        .pll_reset(pll_reset), .pll_reset_p(pll_reset_p),
        .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
        .cfg_req(cfg_req), .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel),
        .cfg_odsel(cfg_odsel), .cfg_ack(cfg_ack), .locked(locked),
        .sys_rst(sys_rst), .fail(fail)
    );

    always #5 clkin = ~clkin;

    initial begin
        #500000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    // Ticks until pll_reset equals lvl; n = ticks taken, -1 if the bound expires.
    task automatic wait_rst_level(input logic lvl, output int n);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (pll_reset === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_locked_level(input logic lvl, output int n);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (locked === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    // Lock waveform: wave[r] is applied right after the r-th edge following pll_reset falling.
    function automatic logic [63:0] make_wave(input int d, input int h1, input int l1,
                                              input int h2, input int l2);
        logic [63:0] w;
        int idx;
        w = '1;
        idx = 0;
        for (int i = 0; i < d;  i++) begin w[idx] = 1'b0; idx++; end
        idx += h1;
        for (int i = 0; i < l1; i++) begin w[idx] = 1'b0; idx++; end
        idx += h2;
        for (int i = 0; i < l2; i++) begin w[idx] = 1'b0; idx++; end
        return w;
    endfunction

    // Reference: locked rises at the first edge e (counted from pll_reset falling) where the
    // LOCK_FILT inputs seen through the 2-cycle synchroniser were all high, the filter having
    // started at the WAIT_LOCK entry edge, and no later than the timeout edge.
    // pre is the lock level driven before pll_reset fell.
    function automatic int model_lock(input logic [63:0] w, input logic pre);
        logic ok;
        logic b;
        for (int e = FILT; e <= TMO; e++) begin
            ok = 1'b1;
            for (int k = e - FILT - 2; k <= e - 3; k++) begin
                b = (k < 0) ? pre : w[k[5:0]];
                if (b !== 1'b1) ok = 1'b0;
            end
            if (ok) return e;
        end
        return -1;
    endfunction

    // Plays a waveform from the pll_reset-fall sample until locked rises; e = ticks or -1.
    task automatic run_wait(input logic [63:0] w, output int e);
        e = -1;
        pll_lock = w[0];
        for (int r = 1; r <= TMO + 5; r++) begin
            tick();
            if (locked === 1'b1) begin
                e = r;
                break;
            end
            pll_lock = (r < 64) ? w[r[5:0]] : 1'b1;
        end
        pll_lock = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; pll_lock = 1'b0; cfg_req = 1'b0;
        repeat (3) tick();
        checks++; if (pll_reset !== 1'b1)   begin errors++; $display("FAIL rst_pll_reset got %b want 1", pll_reset); end
        checks++; if (pll_reset_p !== 1'b1) begin errors++; $display("FAIL rst_pll_reset_p got %b want 1", pll_reset_p); end
        checks++; if (locked !== 1'b0)      begin errors++; $display("FAIL rst_locked got %b want 0", locked); end
        checks++; if (sys_rst !== 1'b1)     begin errors++; $display("FAIL rst_sys_rst got %b want 1", sys_rst); end
        checks++; if (fail !== 1'b0)        begin errors++; $display("FAIL rst_fail got %b want 0", fail); end
        checks++; if (cfg_ack !== 1'b0)     begin errors++; $display("FAIL rst_cfg_ack got %b want 0", cfg_ack); end
        checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== SEL_INIT) begin
            errors++; $display("FAIL rst_sel got %h want %h", {pll_idsel, pll_fbdsel, pll_odsel}, SEL_INIT);
        end
        rst = 1'b0;
        wait_rst_level(1'b0, n);
        checks++; if (n !== RST_C) begin errors++; $display("FAIL rst_release_to_fall got %0d want %0d", n, RST_C); end
        checks++; if (pll_reset_p !== 1'b0) begin errors++; $display("FAIL rst_reset_p_fall got %b want 0", pll_reset_p); end
    endtask

    task automatic test_lock_basic(input int d);
        logic [63:0] w;
        int exp_e, e;
        w = make_wave(d, 0, 0, 0, 0);
        exp_e = model_lock(w, 1'b0);
        run_wait(w, e);
        checks++; if (e !== exp_e)        begin errors++; $display("FAIL lock_basic_edge got %0d want %0d", e, exp_e); end
        checks++; if (e !== d + FILT + 2) begin errors++; $display("FAIL lock_basic_latency got %0d want %0d", e - d, FILT + 2); end
        checks++; if (sys_rst !== 1'b0)   begin errors++; $display("FAIL lock_basic_sys_rst got %b want 0", sys_rst); end
        checks++; if (pll_reset !== 1'b0) begin errors++; $display("FAIL lock_basic_pll_reset got %b want 0", pll_reset); end
    endtask

    task automatic test_lock_loss(input int trial);
        logic [63:0] w;
        int n, exp_e, e;
        pll_lock = 1'b0;
        wait_locked_level(1'b0, n);
        checks++; if (n !== 3)            begin errors++; $display("FAIL loss_latency t%0d got %0d want 3", trial, n); end
        checks++; if (pll_reset !== 1'b1) begin errors++; $display("FAIL loss_pll_reset t%0d got %b want 1", trial, pll_reset); end
        wait_rst_level(1'b0, n);
        checks++; if (n !== RST_C)        begin errors++; $display("FAIL loss_reset_len t%0d got %0d want %0d", trial, n, RST_C); end
        if (trial == 0) w = make_wave(2, 5, 1, 0, 0);
        else w = make_wave($urandom_range(0, 6), $urandom_range(1, FILT - 1), $urandom_range(1, 3),
                           $urandom_range(1, FILT - 1), $urandom_range(1, 3));
        exp_e = model_lock(w, 1'b0);
        run_wait(w, e);
        checks++; if (e !== exp_e)     begin errors++; $display("FAIL relock_edge t%0d got %0d want %0d", trial, e, exp_e); end
        checks++; if (fail !== 1'b0)   begin errors++; $display("FAIL relock_fail t%0d got %b want 0", trial, fail); end
    endtask

    task automatic test_timeout_fail();
        int n;
        pll_lock = 1'b0;
        wait_locked_level(1'b0, n);
        wait_rst_level(1'b0, n);
        checks++; if (n !== RST_C) begin errors++; $display("FAIL tmo_reset1 got %0d want %0d", n, RST_C); end
        wait_rst_level(1'b1, n);
        checks++; if (n !== TMO)     begin errors++; $display("FAIL tmo_first got %0d want %0d", n, TMO); end
        checks++; if (fail !== 1'b0) begin errors++; $display("FAIL tmo_first_fail got %b want 0", fail); end
        wait_rst_level(1'b0, n);
        checks++; if (n !== RST_C)   begin errors++; $display("FAIL tmo_reset2 got %0d want %0d", n, RST_C); end
        wait_rst_level(1'b1, n);
        checks++; if (n !== TMO)      begin errors++; $display("FAIL tmo_second got %0d want %0d", n, TMO); end
        checks++; if (fail !== 1'b1)  begin errors++; $display("FAIL tmo_fail got %b want 1", fail); end
        checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL tmo_sys_rst got %b want 1", sys_rst); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({pll_reset, fail, locked} !== 3'b110) begin
                errors++; $display("FAIL fail_hold c%0d got %b want 110", i, {pll_reset, fail, locked});
            end
        end
    endtask

    task automatic test_fail_exit();
`ifdef PLL_SEQ_RECONF_EN
        logic [17:0] want;
        int n, e;
        want = {6'($urandom), 6'($urandom), 6'($urandom)};
        {cfg_idsel, cfg_fbdsel, cfg_odsel} = want;
        pll_lock = 1'b1;
        cfg_req = 1'b1;
        tick();
        checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL failx_ack got %b want 1", cfg_ack); end
        checks++; if (fail !== 1'b0)    begin errors++; $display("FAIL failx_fail got %b want 0", fail); end
        checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== want) begin
            errors++; $display("FAIL failx_sel got %h want %h", {pll_idsel, pll_fbdsel, pll_odsel}, want);
        end
        cfg_req = 1'b0;
        tick();
        checks++; if ({cfg_ack, pll_reset} !== 2'b01) begin errors++; $display("FAIL failx_after got %b want 01", {cfg_ack, pll_reset}); end
        wait_rst_level(1'b0, n);
        checks++; if (n !== RST_C) begin errors++; $display("FAIL failx_reset got %0d want %0d", n, RST_C); end
        run_wait('1, e);
        checks++; if (e !== model_lock('1, 1'b1)) begin errors++; $display("FAIL failx_relock got %0d want %0d", e, model_lock('1, 1'b1)); end
`else
        cfg_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({cfg_ack, fail} !== 2'b01) begin errors++; $display("FAIL fail_cfg_ignored c%0d got %b want 01", i, {cfg_ack, fail}); end
        end
        cfg_req = 1'b0;
`endif
    endtask

    task automatic test_reconf(input logic [5:0] id, input logic [5:0] fb, input logic [5:0] od);
`ifdef PLL_SEQ_RECONF_EN
        int n, e;
        {cfg_idsel, cfg_fbdsel, cfg_odsel} = {id, fb, od};
        cfg_req = 1'b1;
        tick();
        checks++; if ({cfg_ack, pll_reset} !== 2'b10) begin errors++; $display("FAIL reconf_ack got %b want 10", {cfg_ack, pll_reset}); end
        checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {id, fb, od}) begin
            errors++; $display("FAIL reconf_sel got %h want %h", {pll_idsel, pll_fbdsel, pll_odsel}, {id, fb, od});
        end
        cfg_req = 1'b0;
        tick();
        checks++; if ({cfg_ack, pll_reset} !== 2'b01) begin errors++; $display("FAIL reconf_next got %b want 01", {cfg_ack, pll_reset}); end
        wait_rst_level(1'b0, n);
        checks++; if (n !== RST_C) begin errors++; $display("FAIL reconf_reset got %0d want %0d", n, RST_C); end
        run_wait('1, e);
        checks++; if (e !== model_lock('1, 1'b1)) begin errors++; $display("FAIL reconf_relock got %0d want %0d", e, model_lock('1, 1'b1)); end
`else
        {cfg_idsel, cfg_fbdsel, cfg_odsel} = {id, fb, od};
        cfg_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({cfg_ack, locked} !== 2'b01 || {pll_idsel, pll_fbdsel, pll_odsel} !== SEL_INIT) begin
                errors++; $display("FAIL cfg_ignored c%0d got %b_%h want 01_%h", i, {cfg_ack, locked},
                                   {pll_idsel, pll_fbdsel, pll_odsel}, SEL_INIT);
            end
        end
        cfg_req = 1'b0;
`endif
    endtask

    task automatic test_pending();
`ifdef PLL_SEQ_RECONF_EN
        logic [17:0] want;
        int ack_at, lock_at;
        want = {6'($urandom), 6'($urandom), 6'($urandom)};
        pll_lock = 1'b0;
        tick();
        tick();
        {cfg_idsel, cfg_fbdsel, cfg_odsel} = want;
        cfg_req = 1'b1;
        tick();
        checks++; if ({cfg_ack, locked, pll_reset} !== 3'b001) begin
            errors++; $display("FAIL pend_priority got %b want 001", {cfg_ack, locked, pll_reset});
        end
        pll_lock = 1'b1;
        ack_at = -1; lock_at = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (locked === 1'b1 && lock_at < 0) lock_at = i;
            if (cfg_ack === 1'b1) begin ack_at = i; break; end
        end
        cfg_req = 1'b0;
        checks++; if (lock_at !== RST_C + FILT) begin errors++; $display("FAIL pend_relock got %0d want %0d", lock_at, RST_C + FILT); end
        checks++; if (ack_at !== RST_C + FILT + 1) begin errors++; $display("FAIL pend_ack got %0d want %0d", ack_at, RST_C + FILT + 1); end
        checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== want) begin
            errors++; $display("FAIL pend_sel got %h want %h", {pll_idsel, pll_fbdsel, pll_odsel}, want);
        end
        wait_locked_level(1'b1, ack_at);
        checks++; if (ack_at !== RST_C + FILT + 1) begin errors++; $display("FAIL pend_final_lock got %0d want %0d", ack_at, RST_C + FILT + 1); end
`endif
    endtask

    initial begin
        test_reset();
        test_lock_basic(10);
        for (int t = 0; t < 5; t++) test_lock_loss(t);
        test_timeout_fail();
        test_fail_exit();
        test_reset();
        test_lock_basic(int'($urandom_range(0, 20)));
        test_reconf(6'd5, 6'd24, 6'd8);
        test_reconf(6'($urandom), 6'($urandom), 6'($urandom));
        test_pending();
        test_lock_loss(9);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_seq.md
# pll_seq

PLL reset/lock sequencer for the Gowin rPLL clock generator. Runs on the PLL reference clock: holds the PLL in reset after power-up, filters LOCK, and releases a clean downstream reset only once lock is stable. Recovers automatically from lock loss. Optionally applies new IDSEL/FBDSEL/ODSEL divider settings at run time through a request/acknowledge handshake, then relocks.

## Interface
- `RST_CYCLES`, default 24: cycles `pll_reset` is held high per attempt (1 µs at 24 MHz).
- `LOCK_FILT`, default 256: consecutive synchronised-lock-high cycles required to declare lock.
- `LOCK_TIMEOUT`, default 24000: cycles allowed in WAIT_LOCK before an attempt counts as failed.
- `MAX_RETRY`, default 3: failed attempts before entering FAIL.
- `SEL_INIT`, default 18'h0: reset value of {idsel, fbdsel, odsel}, in the rPLL dynamic-select encoding, passed through unmodified.

Ports:
- `clkin` in 1: PLL reference clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `pll_lock` in 1: raw rPLL LOCK, asynchronous to `clkin`.
- `pll_reset` out 1: drives rPLL RESET.
- `pll_reset_p` out 1: drives rPLL RESET_P; always equal to `pll_reset`.
- `pll_idsel`, `pll_fbdsel`, `pll_odsel` out 6 each: drive rPLL IDSEL/FBDSEL/ODSEL.
- `cfg_req` in 1: level request to apply new divider settings.
- `cfg_idsel`, `cfg_fbdsel`, `cfg_odsel` in 6 each: requested settings; must be stable while `cfg_req` is high.
- `cfg_ack` out 1: one-cycle acknowledge.
- `locked` out 1: filtered lock.
- `sys_rst` out 1: downstream active-high reset, equal to `!locked`.
- `fail` out 1: set when MAX_RETRY is exhausted.

## Operation
- `pll_lock` passes through a 2-flop synchroniser (`lock_s`) before use.
- States: RESET, WAIT_LOCK, LOCKED, RECONF, FAIL.
- **RESET**
  - `pll_reset`=1.
  - Counts RST_CYCLES, then goes to WAIT_LOCK; the filter and timeout counters are cleared on exit.
- **WAIT_LOCK**
  - `pll_reset`=0. The timeout counter increments every cycle.
  - The filter counter increments while `lock_s`=1 and clears when `lock_s`=0.
  - Filter reaching LOCK_FILT → LOCKED; retry counter cleared.
  - Timeout reaching LOCK_TIMEOUT (and filter not done) → retry++. Go to FAIL if retry == MAX_RETRY, otherwise go to RESET.
  - If the filter and timeout complete in the same cycle, the filter wins.
- **LOCKED**
  - `locked`=1, `sys_rst`=0.
  - `lock_s`=0 → RESET; the retry counter is not incremented.
  - `cfg_req`=1 → RECONF.
  - If lock loss and `cfg_req` occur in the same cycle, lock loss wins. The request remains pending and is serviced on the next LOCKED or FAIL.
- **RECONF** (one cycle)
  - Loads `cfg_*` into `pll_*sel` and pulses `cfg_ack`=1.
  - Clears the retry counter and goes to RESET.
- **FAIL**
  - `pll_reset`=1, `fail`=1, `sys_rst`=1.
  - `cfg_req` → RECONF, which clears `fail`. Otherwise FAIL is left only via `rst`.
- **Handshake**
  - The requester holds `cfg_req` until `cfg_ack`, then drops it for at least one cycle.
  - `cfg_req` is ignored in RESET and WAIT_LOCK.
- **Widths**: each counter is `$clog2(param+1)` bits; counters saturate and never wrap.

## Timing
- Reset values:
  - state=RESET, `pll_reset`=`pll_reset_p`=1.
  - `locked`=0, `sys_rst`=1, `fail`=0, `cfg_ack`=0.
  - `pll_*sel`=SEL_INIT, all counters 0.
- `rst` asserted mid-operation behaves exactly like power-up; `pll_*sel` return to SEL_INIT.
- All outputs are registered.
- From `rst` release to `pll_reset` falling: RST_CYCLES cycles.
- From the first stable `pll_lock` edge to `locked`=1: LOCK_FILT+2 cycles (2 synchroniser cycles + filter). `sys_rst` falls in the same cycle.
- From `pll_lock` falling (in LOCKED) to `locked`=0 and `pll_reset`=1: 3 cycles.
- From `cfg_req` rising (in LOCKED) to `cfg_ack`: 1 cycle. New `pll_*sel` values are visible in that same cycle, and `pll_reset`=1 follows on the next.

## Configuration
- `PLL_SEQ_RECONF_EN` defined: dynamic reconfiguration as described above.
- Not defined:
  - RECONF state, `cfg_*` handling and the sel registers are compiled out.
  - `cfg_req` is ignored, `cfg_ack` is tied to 0, and `pll_*sel` are constant SEL_INIT.
  - FAIL is left only via `rst`.

## Structure
- Shared package `pll_pkg`:
  - state enum `pll_state_t`.
  - `typedef struct packed {logic [5:0] idsel, fbdsel, odsel;} pll_sel_t`.
  - SEL width constant.
- One sub-module, `pll_lock_sync`: 2-flop synchroniser plus the LOCK_FILT consecutive-high filter counter, with a clear input.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_FILT=8, LOCK_TIMEOUT=50, MAX_RETRY=2.
- Release `rst`; raise `pll_lock` 10 cycles after `pll_reset` falls → `pll_reset` falls 4 cycles after `rst` release; `locked`/`sys_rst` toggle exactly 10 cycles after `pll_lock` rises.
- Glitch `pll_lock` high 5 cycles, low 1, then high → `locked` asserts only 10 cycles after the final rise.
- Hold `pll_lock`=0 → two 50-cycle timeouts, then `fail`=1 with `pll_reset`=1 held; `locked` stays 0.
- While LOCKED, drop `pll_lock` → `locked`=0 and `pll_reset`=1 after 3 cycles; relock succeeds with `fail`=0.
- With `PLL_SEQ_RECONF_EN` defined, in LOCKED send `cfg_req` with idsel=6'd5, fbdsel=6'd24, odsel=6'd8 → one-cycle `cfg_ack`, `pll_*sel` updated, full RESET→WAIT_LOCK→LOCKED sequence follows.
- Same cycle as `cfg_req`, drop `pll_lock` → no `cfg_ack` until LOCKED is regained; then `cfg_ack` is issued.
